// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Optional performance counters are enabled by defining IFID_PERF_CNT_EN.
module ifid_skid_reg #(
  parameter int unsigned         INSTR_W   = 8,
  parameter int unsigned         PC_W      = 8,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  input  logic               branch_taken,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [1:0]         occupancy
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [15:0]        perf_stall_cnt,
  output logic [15:0]        perf_flush_cnt
`endif
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic               kill_c;
  logic               acc_c;
  logic               pop_c;

  // Handshake flags come straight from the state register, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = 2'(state_q);
  assign out_instr = main_instr_q;
  assign out_pc    = main_pc_q;

  assign kill_c = flush | branch_taken;
  assign acc_c  = in_valid & in_ready;
  assign pop_c  = out_valid & out_ready;

  // Next-state and datapath selection; the head register is kept at NOP whenever empty.
  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (kill_c) begin
      state_d      = EMPTY;
      main_instr_d = NOP_INSTR;
      main_pc_d    = '0;
      skid_instr_d = NOP_INSTR;
      skid_pc_d    = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc_c) begin
            state_d      = ONE;
            main_instr_d = in_instr;
            main_pc_d    = in_pc;
          end
        end
        ONE: begin
          if (acc_c && pop_c) begin
            main_instr_d = in_instr;
            main_pc_d    = in_pc;
          end else if (acc_c) begin
            state_d      = TWO;
            skid_instr_d = in_instr;
            skid_pc_d    = in_pc;
          end else if (pop_c) begin
            state_d      = EMPTY;
            main_instr_d = NOP_INSTR;
            main_pc_d    = '0;
          end
        end
        TWO: begin
          if (pop_c) begin
            state_d      = ONE;
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
            skid_instr_d = NOP_INSTR;
            skid_pc_d    = '0;
          end
        end
        default: begin
          state_d      = EMPTY;
          main_instr_d = NOP_INSTR;
          main_pc_d    = '0;
          skid_instr_d = NOP_INSTR;
          skid_pc_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters, cleared only by reset.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (kill_c && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Bench for ifid_skid_reg: vector table with explicit expectations plus a FIFO reference queue.
module tb_ifid_skid_reg;

  localparam int unsigned IW = 8;
  localparam int unsigned PW = 8;
  localparam logic [IW-1:0] NOP = 8'h00;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic [PW-1:0] in_pc;
  logic          flush;
  logic          branch_taken;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [PW-1:0] out_pc;
  logic [1:0]    occupancy;
`ifdef IFID_PERF_CNT_EN
  logic [15:0]   perf_stall_cnt;
  logic [15:0]   perf_flush_cnt;
`endif

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [PW-1:0] pc;
  } beat_t;

  typedef struct {
    logic          v;
    logic [IW-1:0] ins;
    logic [PW-1:0] pc;
    logic          fl;
    logic          br;
    logic          ordy;
    logic          e_v;
    logic [IW-1:0] e_ins;
    logic [PW-1:0] e_pc;
    logic [1:0]    e_occ;
    logic          e_rdy;
  } vec_t;

  beat_t q[$];
  int    total = 0;
  int    bad   = 0;

  ifid_skid_reg #(.INSTR_W(IW), .PC_W(PW), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .flush        (flush),
    .branch_taken (branch_taken),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .occupancy    (occupancy)
`ifdef IFID_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Compare DUT outputs against the reference queue.
  task automatic check_model(input string tag);
    logic [IW-1:0] e_ins;
    logic [PW-1:0] e_pc;
    e_ins = (q.size() > 0) ? q[0].instr : NOP;
    e_pc  = (q.size() > 0) ? q[0].pc : '0;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(q.size()));
    chk({tag, ".out_instr"}, 32'(out_instr), 32'(e_ins));
    chk({tag, ".out_pc"},    32'(out_pc),    32'(e_pc));
  endtask

  // One clock: drive inputs, score any delivered beat, update the reference, recheck.
  task automatic step(input logic v, input logic [IW-1:0] ins, input logic [PW-1:0] pc,
                      input logic fl, input logic br, input logic ordy, input string tag);
    logic mv, mr, pop, acc;
    in_valid = v; in_instr = ins; in_pc = pc;
    flush = fl; branch_taken = br; out_ready = ordy;
    mv  = (q.size() > 0);
    mr  = (q.size() < 2);
    pop = mv & ordy;
    acc = v & mr;
    if (pop) begin
      chk({tag, ".deliver_instr"}, 32'(out_instr), 32'(q[0].instr));
      chk({tag, ".deliver_pc"},    32'(out_pc),    32'(q[0].pc));
    end
    @(posedge clk);
    if (fl | br) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(beat_t'{ins, pc});
    end
    #1;
    check_model(tag);
  endtask

  vec_t tbl[21];

  initial begin
    // stimulus and post-edge expectations
    tbl[0]  = '{1'b1, 8'hA1, 8'h10, 1'b0, 1'b0, 1'b1,  1'b1, 8'hA1, 8'h10, 2'd1, 1'b1};
    tbl[1]  = '{1'b1, 8'hA2, 8'h11, 1'b0, 1'b0, 1'b1,  1'b1, 8'hA2, 8'h11, 2'd1, 1'b1};
    tbl[2]  = '{1'b1, 8'hA3, 8'h12, 1'b0, 1'b0, 1'b1,  1'b1, 8'hA3, 8'h12, 2'd1, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1,  1'b0, 8'h00, 8'h00, 2'd0, 1'b1};
    tbl[4]  = '{1'b1, 8'hB1, 8'h20, 1'b0, 1'b0, 1'b0,  1'b1, 8'hB1, 8'h20, 2'd1, 1'b1};
    tbl[5]  = '{1'b1, 8'hB2, 8'h21, 1'b0, 1'b0, 1'b0,  1'b1, 8'hB1, 8'h20, 2'd2, 1'b0};
    tbl[6]  = '{1'b1, 8'hB3, 8'h22, 1'b0, 1'b0, 1'b0,  1'b1, 8'hB1, 8'h20, 2'd2, 1'b0};
    tbl[7]  = '{1'b1, 8'hB3, 8'h22, 1'b0, 1'b0, 1'b1,  1'b1, 8'hB2, 8'h21, 2'd1, 1'b1};
    tbl[8]  = '{1'b1, 8'hB3, 8'h22, 1'b0, 1'b0, 1'b1,  1'b1, 8'hB3, 8'h22, 2'd1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0,  1'b1, 8'hB3, 8'h22, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1,  1'b0, 8'h00, 8'h00, 2'd0, 1'b1};
    tbl[11] = '{1'b1, 8'hD1, 8'h28, 1'b0, 1'b0, 1'b0,  1'b1, 8'hD1, 8'h28, 2'd1, 1'b1};
    tbl[12] = '{1'b1, 8'hD2, 8'h29, 1'b0, 1'b0, 1'b0,  1'b1, 8'hD1, 8'h28, 2'd2, 1'b0};
    tbl[13] = '{1'b1, 8'hC0, 8'h30, 1'b1, 1'b0, 1'b0,  1'b0, 8'h00, 8'h00, 2'd0, 1'b1};
    tbl[14] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1,  1'b0, 8'h00, 8'h00, 2'd0, 1'b1};
    tbl[15] = '{1'b1, 8'hE1, 8'h40, 1'b0, 1'b0, 1'b0,  1'b1, 8'hE1, 8'h40, 2'd1, 1'b1};
    tbl[16] = '{1'b1, 8'hE2, 8'h41, 1'b0, 1'b1, 1'b1,  1'b0, 8'h00, 8'h00, 2'd0, 1'b1};
    tbl[17] = '{1'b1, 8'hF1, 8'h50, 1'b0, 1'b0, 1'b1,  1'b1, 8'hF1, 8'h50, 2'd1, 1'b1};
    tbl[18] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1,  1'b0, 8'h00, 8'h00, 2'd0, 1'b1};
    tbl[19] = '{1'b1, 8'h99, 8'h60, 1'b1, 1'b0, 1'b1,  1'b0, 8'h00, 8'h00, 2'd0, 1'b1};
    tbl[20] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1,  1'b0, 8'h00, 8'h00, 2'd0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; branch_taken = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    reset = 1'b0;

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tbl[i].v, tbl[i].ins, tbl[i].pc, tbl[i].fl, tbl[i].br, tbl[i].ordy, tag);
      chk({tag, ".exp_valid"}, 32'(out_valid), 32'(tbl[i].e_v));
      chk({tag, ".exp_instr"}, 32'(out_instr), 32'(tbl[i].e_ins));
      chk({tag, ".exp_pc"},    32'(out_pc),    32'(tbl[i].e_pc));
      chk({tag, ".exp_occ"},   32'(occupancy), 32'(tbl[i].e_occ));
      chk({tag, ".exp_rdy"},   32'(in_ready),  32'(tbl[i].e_rdy));
    end

    // Reset asserted while full discards both entries.
    step(1'b1, 8'h71, 8'h70, 1'b0, 1'b0, 1'b0, "mid_fill1");
    step(1'b1, 8'h72, 8'h71, 1'b0, 1'b0, 1'b0, "mid_fill2");
    chk("mid_full_occ", 32'(occupancy), 32'd2);
    reset = 1'b1; in_valid = 1'b1; in_instr = 8'h73; out_ready = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    reset = 1'b0;
    check_model("mid_reset");
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "post_reset_idle");
    step(1'b1, 8'h81, 8'h80, 1'b0, 1'b0, 1'b1, "post_reset_push");

`ifdef IFID_PERF_CNT_EN
    reset = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    reset = 1'b0;
    chk("perf_rst_stall", 32'(perf_stall_cnt), 32'd0);
    chk("perf_rst_flush", 32'(perf_flush_cnt), 32'd0);
    step(1'b1, 8'h91, 8'h90, 1'b0, 1'b0, 1'b0, "perf_push");
    for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "perf_stall");
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, "perf_flush1");
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, "perf_flush2");
    chk("perf_stall_5", 32'(perf_stall_cnt), 32'd5);
    chk("perf_flush_2", 32'(perf_flush_cnt), 32'd2);
    step(1'b1, 8'h92, 8'h91, 1'b0, 1'b0, 1'b0, "perf_push2");
    out_ready = 1'b0; in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("perf_stall_sat", 32'(perf_stall_cnt), 32'h0000FFFF);
    chk("perf_flush_hold", 32'(perf_flush_cnt), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
